// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps per operation. Operands are reduced to magnitudes on accept.
// Signs are reapplied at the finish edge.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_src_a,
   input  logic [WIDTH-1:0] i_src_b,
   input  logic             i_mthi,
   input  logic             i_mtlo,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;     // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   r_opnd;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done;

   logic               w_accept, w_finish;
   logic               w_sa, w_sb;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_sum, w_shift;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_step, w_prod;
   logic [WIDTH-1:0]   w_quot, w_rem;

   assign w_accept = i_start && (r_state == S_IDLE);
   assign w_finish = (r_state == S_RUN) && (r_cnt == '0);

   // Operand magnitudes: op[0]=0 selects the signed variants
   always_comb begin
      w_sa    = ~i_op[0] & i_src_a[WIDTH-1];
      w_sb    = ~i_op[0] & i_src_b[WIDTH-1];
      w_mag_a = w_sa ? -i_src_a : i_src_a;
      w_mag_b = w_sb ? -i_src_b : i_src_b;
   end

   // One iteration step plus sign fix-up of the final step's value
   always_comb begin
      // shift-add: add multiplicand into the upper half when multiplier LSB is set, then shift right
      w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
      // restoring: bring next dividend bit into the remainder, subtract divisor if it fits
      w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff    = w_shift[WIDTH-1:0] - r_opnd;
      if (w_shift < {1'b0, r_opnd})
         w_div_nxt = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else
         w_div_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
      w_acc_step = r_is_div ? w_div_nxt : w_mul_nxt;
      w_prod     = r_neg_q ? -w_acc_step : w_acc_step;
      // divide by zero leaves |A| in the remainder, so sign fix-up already returns SrcA
      w_quot     = r_dz ? '1 : (r_neg_q ? -w_acc_step[WIDTH-1:0] : w_acc_step[WIDTH-1:0]);
      w_rem      = r_neg_r ? -w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[2*WIDTH-1:WIDTH];
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_finish) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture on accept, one step per RUN cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= CW'(WIDTH - 1);
         r_is_div <= i_op[1];
         r_neg_q  <= w_sa ^ w_sb;
         r_neg_r  <= w_sa;
         r_dz     <= i_op[1] && (i_src_b == '0);
         r_opnd   <= i_op[1] ? w_mag_b : w_mag_a;
         r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_step;
         if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end
   end

   // HI/LO: full result at finish, MTHI/MTLO only while idle and Start not taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_finish) begin
            r_hi <= r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_is_div ? w_quot : w_prod[WIDTH-1:0];
         end else if ((r_state == S_IDLE) && !i_start) begin
            if (i_mthi) r_hi <= i_src_a;
            if (i_mtlo) r_lo <= i_src_a;
         end
      end
   end

   assign o_busy = (r_state == S_RUN);
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected HI/LO and the
// due cycle into a scoreboard; a monitor pops and compares on every Done.
module tb_muldiv_unit;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        o_busy, o_done;
   logic [31:0] o_hi, o_lo;

   muldiv_unit #(.WIDTH(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
      .i_src_a(a), .i_src_b(b), .i_mthi(mthi), .i_mtlo(mtlo),
      .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      string       name;
   } exp_t;
   exp_t q[$];

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && o_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got Done at cycle %0d expected none", cyc);
         end else begin
            e = q.pop_front();
            chk({e.name, "_hi"}, o_hi, e.hi);
            chk({e.name, "_lo"}, o_lo, e.lo);
            chk({e.name, "_done_cycle"}, cyc, e.due);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] sa, input logic [31:0] sb,
                        input logic [31:0] eh, input logic [31:0] el, input bit push,
                        input string nm);
      exp_t e;
      op = o; a = sa; b = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (push) begin
         e.hi = eh; e.lo = el; e.due = cyc + 32; e.name = nm;
         q.push_back(e);
      end
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_done && n < 100);
      if (!o_done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no Done in %0d cycles expected Done", nm, n);
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_done", {31'b0, o_done}, 32'd0);
      chk("rst_hi", o_hi, 32'd0);
      chk("rst_lo", o_lo, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, "mult_m3x5");
      @(negedge clk);
      chk("busy_after_accept", {31'b0, o_busy}, 32'd1);
      chk("no_early_done", {31'b0, o_done}, 32'd0);
      wait_done("mult_m3x5");
      chk("busy_low_in_done_cycle", {31'b0, o_busy}, 32'd0);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, "multu_max");
      wait_done("multu_max");
      // back-to-back: Start driven during the Done cycle
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1, "divu_b2b");
      @(negedge clk);
      chk("b2b_busy", {31'b0, o_busy}, 32'd1);
      wait_done("divu_b2b");

      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, "div_m7d2");
      wait_done("div_m7d2");
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1, "div_minovf");
      wait_done("div_minovf");
      issue(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1, "divu_by0");
      wait_done("divu_by0");
      issue(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, "div_neg_by0");
      wait_done("div_neg_by0");

      // Start and MtLo during RUN are ignored
      issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1, "mult_6x7");
      repeat (9) @(posedge clk);
      #1;
      op = 2'b11; a = 32'h0000_DEAD; b = 32'd3; start = 1'b1; mtlo = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      @(negedge clk);
      chk("mtlo_ignored_busy", o_lo, 32'hFFFF_FFFF);
      chk("still_busy", {31'b0, o_busy}, 32'd1);
      wait_done("mult_6x7");

      // MTHI in idle
      a = 32'hA5A5_A5A5; mthi = 1'b1;
      @(posedge clk); #1;
      mthi = 1'b0;
      @(negedge clk);
      chk("mthi_hi", o_hi, 32'hA5A5_A5A5);
      chk("mthi_lo_kept", o_lo, 32'd42);
      chk("mthi_no_done", {31'b0, o_done}, 32'd0);

      // MTHI and MTLO together
      a = 32'h1122_3344; mthi = 1'b1; mtlo = 1'b1;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      @(negedge clk);
      chk("mtboth_hi", o_hi, 32'h1122_3344);
      chk("mtboth_lo", o_lo, 32'h1122_3344);

      // Start wins over a simultaneous MTHI
      mthi = 1'b1;
      issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1, "mult_start_wins");
      @(negedge clk);
      chk("mthi_dropped", o_hi, 32'h1122_3344);
      wait_done("mult_start_wins");

      // reset mid-operation aborts without a Done
      a = 32'hA5A5_A5A5; mthi = 1'b1;
      @(posedge clk); #1;
      mthi = 1'b0;
      issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 0, "abort");
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, o_busy}, 32'd0);
      chk("abort_done", {31'b0, o_done}, 32'd0);
      chk("abort_hi", o_hi, 32'd0);
      chk("abort_lo", o_lo, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("idle_after_abort", {31'b0, o_busy}, 32'd0);
      chk("scoreboard_drained", q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
